uart_tx_arbiter: RTL

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

---
 rtl/uart_tx_arbiter_if.sv | 33 +++
 rtl/uart_tx_arbiter.sv | 113 +++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter_if.sv
// rtl/uart_tx_arbiter_if.sv - requester, UART-core and status signals of the two-requester UART transmit arbiter
interface uart_tx_arbiter_if;
    logic       req0_valid;
    logic [7:0] req0_data;
    logic       req0_last;
    logic       req0_ready;
    logic       req1_valid;
    logic [7:0] req1_data;
    logic       req1_last;
    logic       req1_ready;
    logic       transmit;
    logic [7:0] tx_byte;
    logic       is_transmitting;
    logic       grant;
    logic       busy;
    logic       tx_timeout;

    modport master (
        output req0_valid, req0_data, req0_last,
        output req1_valid, req1_data, req1_last,
        output is_transmitting,
        input  req0_ready, req1_ready,
        input  transmit, tx_byte, grant, busy, tx_timeout
    );

    modport slave (
        input  req0_valid, req0_data, req0_last,
        input  req1_valid, req1_data, req1_last,
        input  is_transmitting,
        output req0_ready, req1_ready,
        output transmit, tx_byte, grant, busy, tx_timeout
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin, packet-locking arbiter feeding one UART transmitter
// Bytes are launched with a held transmit strobe and abandoned if the core never starts.
module uart_tx_arbiter #(
    parameter int START_TIMEOUT = 1023
) (
    input logic             clk,
    input logic             rst,
    uart_tx_arbiter_if.slave bus
);
    localparam int CW = (START_TIMEOUT < 2) ? 1 : $clog2(START_TIMEOUT);
    localparam logic [CW-1:0] CNT_LAST = CW'(START_TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, LAUNCH, SHIFT} state_t;

    state_t        state_q;
    logic          transmit_q;
    logic [7:0]    tx_byte_q;
    logic          grant_q;
    logic          busy_q;
    logic          tx_timeout_q;
    logic          locked_q;
    logic          last_q;
    logic [CW-1:0] cnt_q;

    logic       sel_d;
    logic       sel_valid_d;
    logic       accept_d;
    logic [7:0] sel_data_d;
    logic       sel_last_d;

    // A locked packet owner keeps the channel even when the other side is waiting.
    always_comb begin
        sel_d       = ~last_q;
        sel_valid_d = 1'b0;
        if (locked_q) begin
            sel_d       = last_q;
            sel_valid_d = last_q ? bus.req1_valid : bus.req0_valid;
        end else if (bus.req0_valid && bus.req1_valid) begin
            sel_d       = ~last_q;
            sel_valid_d = 1'b1;
        end else if (bus.req0_valid) begin
            sel_d       = 1'b0;
            sel_valid_d = 1'b1;
        end else if (bus.req1_valid) begin
            sel_d       = 1'b1;
            sel_valid_d = 1'b1;
        end
    end

    assign accept_d   = (state_q == IDLE) && !bus.is_transmitting && !rst && sel_valid_d;
    assign sel_data_d = sel_d ? bus.req1_data : bus.req0_data;
    assign sel_last_d = sel_d ? bus.req1_last : bus.req0_last;

    assign bus.req0_ready = accept_d && !sel_d;
    assign bus.req1_ready = accept_d && sel_d;
    assign bus.transmit   = transmit_q;
    assign bus.tx_byte    = tx_byte_q;
    assign bus.grant      = grant_q;
    assign bus.busy       = busy_q;
    assign bus.tx_timeout = tx_timeout_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            transmit_q   <= 1'b0;
            tx_byte_q    <= 8'h00;
            grant_q      <= 1'b0;
            busy_q       <= 1'b0;
            tx_timeout_q <= 1'b0;
            locked_q     <= 1'b0;
            last_q       <= 1'b1;
            cnt_q        <= '0;
        end else begin
            tx_timeout_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (accept_d) begin
                        tx_byte_q  <= sel_data_d;
                        grant_q    <= sel_d;
                        transmit_q <= 1'b1;
                        busy_q     <= 1'b1;
                        last_q     <= sel_d;
                        locked_q   <= ~sel_last_d;
                        cnt_q      <= '0;
                        state_q    <= LAUNCH;
                    end
                end
                LAUNCH: begin
                    if (bus.is_transmitting) begin
                        transmit_q <= 1'b0;
                        state_q    <= SHIFT;
                    end else if (cnt_q == CNT_LAST) begin
                        // Core never started: drop the byte and release any packet lock.
                        transmit_q   <= 1'b0;
                        tx_timeout_q <= 1'b1;
                        busy_q       <= 1'b0;
                        locked_q     <= 1'b0;
                        state_q      <= IDLE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                SHIFT: begin
                    if (!bus.is_transmitting) begin
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule
